// File: rtl/stream_unpacker.sv
// Stream unpacker: splits a stream of packed W-bit words into P-bit values
// (LSB-first, straddling allowed) and returns each sign- or zero-extended to W bits.
module stream_unpacker #(
   parameter int BIT_WIDTH = 16,
   parameter int PREC_BITS = 5,
   parameter int CNT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_cfg_valid,
   output logic                 o_cfg_ready,
   input  logic [PREC_BITS-1:0] i_prec,
   input  logic                 i_signed,
   input  logic [CNT_BITS-1:0]  i_num,
   input  logic                 i_in_valid,
   input  logic [BIT_WIDTH-1:0] i_in,
   output logic                 o_in_ready,
   output logic                 o_out_valid,
   output logic [BIT_WIDTH-1:0] o_out,
   input  logic                 i_out_ready,
   output logic                 o_done,
   output logic                 o_busy,
   output logic                 o_err
);

   localparam int BUF_W  = 2 * BIT_WIDTH;
   localparam int FILL_W = $clog2(BUF_W + 1);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e               state_q;
   logic [PREC_BITS-1:0] prec_q;
   logic                 signed_q;
   logic [CNT_BITS-1:0]  cnt_q;
   logic [BUF_W-1:0]     buf_q, buf_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic                 done_q;
   logic                 err_q;

   logic                 run;
   logic                 push;
   logic                 pop;
   logic                 last_pop;
   logic                 cfg_bad;
   logic                 sign_bit;
   logic [BIT_WIDTH-1:0] val_mask;
   logic [BUF_W-1:0]     shifted;
   logic [FILL_W-1:0]    base;

   assign run         = (state_q == S_RUN);
   assign o_cfg_ready = ~run;
   assign o_busy      = run;
   assign o_done      = done_q;
   assign o_err       = err_q;

   // NOTE: o_in_ready depends on registered fill only, never on i_out_ready, so
   // upstream and downstream handshakes cannot form a combinational path.
   assign o_in_ready  = run && (int'(fill_q) <= BIT_WIDTH);
   assign o_out_valid = run && (int'(fill_q) >= int'(prec_q));

   assign push     = o_in_ready && i_in_valid;
   assign pop      = o_out_valid && i_out_ready;
   assign last_pop = pop && (cnt_q == CNT_BITS'(1));
   assign cfg_bad  = (i_prec == '0) || (int'(i_prec) > BIT_WIDTH);

   // Output value: low P bits of the buffer, upper bits from the extension bit.
   always_comb begin
      val_mask = '0;
      for (int i = 0; i < BIT_WIDTH; i++) begin
         val_mask[i] = (i < int'(prec_q));
      end
   end

   assign sign_bit = signed_q && (prec_q != '0) &&
                     (|(buf_q & (BUF_W'(1) << (prec_q - PREC_BITS'(1)))));
   assign o_out    = (buf_q[BIT_WIDTH-1:0] & val_mask) |
                     (~val_mask & {BIT_WIDTH{sign_bit}});

   // NOTE: bits at and above fill are kept zero (buffer cleared on reset, config
   // and frame end; right shifts bring in zeros), so a push simply ORs in.
   always_comb begin
      shifted = pop ? (buf_q >> prec_q) : buf_q;
      base    = pop ? (fill_q - FILL_W'(prec_q)) : fill_q;
      buf_d   = shifted;
      fill_d  = base;
      if (push) begin
         buf_d  = shifted | (BUF_W'(i_in) << base);
         fill_d = base + FILL_W'(BIT_WIDTH);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         prec_q   <= '0;
         signed_q <= 1'b0;
         cnt_q    <= '0;
         buf_q    <= '0;
         fill_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_cfg_valid) begin
                  prec_q   <= i_prec;
                  signed_q <= i_signed;
                  cnt_q    <= i_num;
                  buf_q    <= '0;
                  fill_q   <= '0;
                  err_q    <= cfg_bad;
                  if (cfg_bad || (i_num == '0)) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (last_pop) begin
                  // Residual padding bits and any word pushed this cycle are dropped.
                  state_q <= S_IDLE;
                  buf_q   <= '0;
                  fill_q  <= '0;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
               end else begin
                  buf_q  <= buf_d;
                  fill_q <= fill_d;
                  if (pop) begin
                     cnt_q <= cnt_q - CNT_BITS'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker: cycle-exact vector table plus
// directed multi-cycle sequences (stall, sign extension, errors, mid-frame reset).
module tb_stream_unpacker;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cfg_valid;
   logic        o_cfg_ready;
   logic [4:0]  i_prec;
   logic        i_signed;
   logic [15:0] i_num;
   logic        i_in_valid;
   logic [15:0] i_in;
   logic        o_in_ready;
   logic        o_out_valid;
   logic [15:0] o_out;
   logic        i_out_ready;
   logic        o_done;
   logic        o_busy;
   logic        o_err;

   int checks   = 0;
   int failures = 0;

   logic [15:0] word_q[$];
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   stream_unpacker #(
      .BIT_WIDTH(16),
      .PREC_BITS(5),
      .CNT_BITS (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_cfg_valid(i_cfg_valid),
      .o_cfg_ready(o_cfg_ready),
      .i_prec     (i_prec),
      .i_signed   (i_signed),
      .i_num      (i_num),
      .i_in_valid (i_in_valid),
      .i_in       (i_in),
      .o_in_ready (o_in_ready),
      .o_out_valid(o_out_valid),
      .o_out      (o_out),
      .i_out_ready(i_out_ready),
      .o_done     (o_done),
      .o_busy     (o_busy),
      .o_err      (o_err)
   );

   typedef struct {
      logic        cfg_valid;
      logic [4:0]  prec;
      logic        sgn;
      logic [15:0] num;
      logic        in_valid;
      logic [15:0] din;
      logic        out_ready;
      logic        cfg_ready;
      logic        in_ready;
      logic        out_valid;
      logic [15:0] dout;
      logic        done;
      logic        busy;
      logic        err;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic cv, input logic [4:0] p, input logic s,
                               input logic [15:0] n, input logic iv, input logic [15:0] din,
                               input logic ordy, input logic cr, input logic ir,
                               input logic ov, input logic [15:0] dout, input logic d,
                               input logic b, input logic e);
      vec_t v;
      v.cfg_valid = cv;  v.prec = p;      v.sgn = s;        v.num = n;
      v.in_valid  = iv;  v.din = din;     v.out_ready = ordy;
      v.cfg_ready = cr;  v.in_ready = ir; v.out_valid = ov; v.dout = dout;
      v.done      = d;   v.busy = b;      v.err = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      i_cfg_valid = 1'b0;
      i_prec      = '0;
      i_signed    = 1'b0;
      i_num       = '0;
      i_in_valid  = 1'b0;
      i_in        = '0;
      i_out_ready = 1'b0;
   endtask

   // Configure a legal frame, feed word_q whenever ready, compare pops to exp_q.
   task automatic run_frame(input string name, input logic [4:0] p, input logic sgn,
                            input logic [15:0] num, input int stall);
      int wi;
      int oi;
      bit seen_done;
      wi = 0;
      oi = 0;
      seen_done = 0;
      i_cfg_valid = 1'b1;
      i_prec      = p;
      i_signed    = sgn;
      i_num       = num;
      check($sformatf("%s cfg_ready", name), o_cfg_ready, 1);
      step();
      i_cfg_valid = 1'b0;
      check($sformatf("%s busy after cfg", name), o_busy, 1);
      check($sformatf("%s err after cfg", name), o_err, 0);
      for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
         i_in_valid  = (wi < word_q.size());
         i_in        = i_in_valid ? word_q[wi] : '0;
         i_out_ready = (cyc >= stall);
         if (cyc >= 1 && cyc < stall)
            check($sformatf("%s stalled out c%0d", name, cyc), {o_out_valid, o_out}, {1'b1, exp_q[0]});
         if (cyc >= 2 && cyc < stall)
            check($sformatf("%s stalled in_ready c%0d", name, cyc), o_in_ready, 0);
         if (o_done) begin
            seen_done = 1;
            check($sformatf("%s value count", name), oi, exp_q.size());
            check($sformatf("%s idle at done", name), {o_busy, o_cfg_ready, o_out_valid}, 3'b010);
         end else begin
            if (o_out_valid && i_out_ready) begin
               if (oi < exp_q.size())
                  check($sformatf("%s value %0d", name, oi), o_out, exp_q[oi]);
               else
                  check($sformatf("%s extra value", name), oi, exp_q.size());
               oi++;
            end
            if (o_in_ready && i_in_valid) wi++;
            step();
         end
      end
      check($sformatf("%s done seen", name), seen_done, 1);
      quiet_inputs();
   endtask

   initial begin
      rst = 1'b1;
      quiet_inputs();
      i_in_valid = 1'b1;
      i_in       = 16'hA5A5;
      step();
      check("reset state", {o_cfg_ready, o_in_ready, o_out_valid, o_done, o_busy, o_err},
            6'b100000);
      check("reset o_out", o_out, 16'h0000);
      step();
      rst = 1'b0;
      quiet_inputs();
      step();

      // P=16 (W boundary) straight-through frame, then P=12 straddling frame.
      vecs[0]  = mk(0, 0,  0, 0, 1, 16'hDEAD, 0,  1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[1]  = mk(1, 16, 0, 3, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[2]  = mk(0, 0,  0, 0, 1, 16'h1234, 1,  0, 1, 0, 16'h0000, 0, 1, 0);
      vecs[3]  = mk(1, 4,  0, 9, 1, 16'h5678, 1,  0, 1, 1, 16'h1234, 0, 1, 0);
      vecs[4]  = mk(0, 0,  0, 0, 1, 16'h9ABC, 1,  0, 1, 1, 16'h5678, 0, 1, 0);
      vecs[5]  = mk(0, 0,  0, 0, 0, 16'h0000, 1,  0, 1, 1, 16'h9ABC, 0, 1, 0);
      vecs[6]  = mk(0, 0,  0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 1, 0, 0);
      vecs[7]  = mk(1, 12, 0, 4, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[8]  = mk(0, 0,  0, 0, 1, 16'hFABC, 1,  0, 1, 0, 16'h0000, 0, 1, 0);
      vecs[9]  = mk(0, 0,  0, 0, 1, 16'h23DE, 1,  0, 1, 1, 16'h0ABC, 0, 1, 0);
      vecs[10] = mk(0, 0,  0, 0, 1, 16'h4561, 1,  0, 0, 1, 16'h0DEF, 0, 1, 0);
      vecs[11] = mk(0, 0,  0, 0, 1, 16'h4561, 1,  0, 1, 0, 16'h0000, 0, 1, 0);
      vecs[12] = mk(0, 0,  0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'h0123, 0, 1, 0);
      vecs[13] = mk(0, 0,  0, 0, 0, 16'h0000, 1,  0, 1, 1, 16'h0456, 0, 1, 0);
      vecs[14] = mk(0, 0,  0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 1, 0, 0);
      vecs[15] = mk(0, 0,  0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0, 0, 0);

      for (int k = 0; k < NV; k++) begin
         i_cfg_valid = vecs[k].cfg_valid;
         i_prec      = vecs[k].prec;
         i_signed    = vecs[k].sgn;
         i_num       = vecs[k].num;
         i_in_valid  = vecs[k].in_valid;
         i_in        = vecs[k].din;
         i_out_ready = vecs[k].out_ready;
         check($sformatf("vec%0d cfg_ready", k), o_cfg_ready, vecs[k].cfg_ready);
         check($sformatf("vec%0d in_ready", k), o_in_ready, vecs[k].in_ready);
         check($sformatf("vec%0d out_valid", k), o_out_valid, vecs[k].out_valid);
         check($sformatf("vec%0d done", k), o_done, vecs[k].done);
         check($sformatf("vec%0d busy", k), o_busy, vecs[k].busy);
         check($sformatf("vec%0d err", k), o_err, vecs[k].err);
         if (vecs[k].out_valid)
            check($sformatf("vec%0d out", k), o_out, vecs[k].dout);
         step();
      end
      quiet_inputs();

      // Signed P=4: nibbles 8,F,0,0 of 0x00F8.
      word_q = '{16'h00F8};
      exp_q  = '{16'hFFF8, 16'hFFFF, 16'h0000, 16'h0000};
      run_frame("signed_p4", 5'd4, 1'b1, 16'd4, 0);

      // P=5 values 1..6 packed into 0x0C520C41, consumer stalled for 10 cycles.
      word_q = '{16'h0C41, 16'h0C52};
      exp_q  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
      run_frame("stall_p5", 5'd5, 1'b0, 16'd6, 10);

      // Illegal precisions P=0 and P=17, then a legal empty frame clears o_err.
      i_cfg_valid = 1'b1; i_prec = 5'd0; i_num = 16'd3;
      step();
      i_cfg_valid = 1'b0;
      check("p0 err/done", {o_err, o_done, o_busy, o_out_valid, o_cfg_ready}, 5'b11001);
      step();
      check("p0 after", {o_err, o_done, o_busy, o_out_valid}, 4'b1000);
      i_cfg_valid = 1'b1; i_prec = 5'd17; i_num = 16'd3;
      step();
      i_cfg_valid = 1'b0;
      check("p17 err/done", {o_err, o_done, o_busy, o_out_valid, o_cfg_ready}, 5'b11001);
      step();
      check("p17 after", {o_err, o_done, o_busy, o_out_valid}, 4'b1000);
      i_cfg_valid = 1'b1; i_prec = 5'd8; i_num = 16'd0;
      step();
      i_cfg_valid = 1'b0;
      check("num0 err/done", {o_err, o_done, o_busy, o_out_valid, o_cfg_ready}, 5'b01001);
      step();
      check("num0 after", {o_err, o_done, o_busy}, 3'b000);

      // Mid-frame reset after 2 of 4 values; inputs during reset are ignored.
      i_cfg_valid = 1'b1; i_prec = 5'd4; i_signed = 1'b0; i_num = 16'd4;
      step();
      i_cfg_valid = 1'b0; i_in_valid = 1'b1; i_in = 16'h4321; i_out_ready = 1'b1;
      check("rst_frame in_ready", o_in_ready, 1);
      step();
      i_in_valid = 1'b0;
      check("rst_frame value 0", {o_out_valid, o_out}, {1'b1, 16'h0001});
      step();
      check("rst_frame value 1", {o_out_valid, o_out}, {1'b1, 16'h0002});
      step();
      check("rst_frame value 2 pending", {o_out_valid, o_out}, {1'b1, 16'h0003});
      rst = 1'b1;
      i_in_valid = 1'b1; i_in = 16'hFFFF;
      i_cfg_valid = 1'b1; i_prec = 5'd8; i_num = 16'd7;
      step();
      check("midreset state", {o_cfg_ready, o_in_ready, o_out_valid, o_done, o_busy, o_err},
            6'b100000);
      check("midreset o_out", o_out, 16'h0000);
      rst = 1'b0;
      quiet_inputs();
      step();
      check("after reset idle", {o_cfg_ready, o_busy, o_done}, 3'b100);

      word_q = '{16'h807F};
      exp_q  = '{16'h007F, 16'hFF80};
      run_frame("post_reset_p8", 5'd8, 1'b1, 16'd2, 0);

      word_q = '{16'hBEEF};
      exp_q  = '{16'hBEEF};
      run_frame("single_p16", 5'd16, 1'b0, 16'd1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
